// File: rtl/aes_enc_pipe_param.sv
// aes_enc_pipe_param: fully pipelined AES-128/256 encryptor with on-chip key expansion,
// valid/ready handshakes, global stall and a tag carried with each block.
module aes_enc_pipe_param #(
    parameter int KEY_LEN = 128,
    parameter int TAG_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_LEN-1:0] key_in,
    input  logic               key_load,
    output logic               key_load_ready,
    output logic               key_ready,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_data,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_data,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int NR = (KEY_LEN == 256) ? 14 : 10;
    localparam int NK = KEY_LEN / 32;

    if (KEY_LEN != 128 && KEY_LEN != 256) begin : g_bad_key_len
        $error("aes_enc_pipe_param: KEY_LEN must be 128 or 256");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0]  p;
        logic [7:0]  inv;
        logic [15:0] t;
        p = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            inv = gmul(inv, p);
        end
        t = {inv, inv};
        return inv ^ t[14:7] ^ t[13:6] ^ t[12:5] ^ t[11:4] ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 2; i <= 10; i++) if (i <= int'(n)) r = xtime(r);
        return r;
    endfunction

    // Byte n of the block sits at bits [127-8n -: 8]; state column c holds bytes 4c..4c+3
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   a [4];
        logic [7:0]   m [4];
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = sbox(s[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8]);
            m[0] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
            m[1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
            m[2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
            m[3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
            for (int r = 0; r < 4; r++) o[127 - 8 * (r + 4 * c) -: 8] = last ? a[r] : m[r];
        end
        return o ^ rk;
    endfunction

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t         state_q;
    logic [3:0]     k_q;
    logic [255:0]   key_q;
    logic [127:0]   a_q, b_q;
    logic [127:0]   bank_q [0:NR];
    logic [127:0]   rk_d;
    logic [31:0]    lw, rw, tmp, w0, w1, w2, w3;
    logic [127:0]   base;
    logic [3:0]     ri;
    logic           rot;
    logic [127:0]   sd_q [0:NR];
    logic [127:0]   sd_d [0:NR];
    logic [TAG_W-1:0] st_q [0:NR];
    logic [NR:0]    sv_q;
    logic           empty, stall, load_go;

    // a_q/b_q hold the two most recent round keys; AES-256 steps from k-2, AES-128 from k-1
    always_comb begin
        rot  = (NK == 4) || !k_q[0];
        ri   = (NK == 8) ? (k_q >> 1) : k_q;
        lw   = b_q[31:0];
        rw   = rot ? {lw[23:0], lw[31:24]} : lw;
        tmp  = subword(rw) ^ (rot ? {rcon(ri), 24'h0} : 32'h0);
        base = (NK == 8) ? a_q : b_q;
        w0   = base[127:96] ^ tmp;
        w1   = base[95:64] ^ w0;
        w2   = base[63:32] ^ w1;
        w3   = base[31:0] ^ w2;
        rk_d = (k_q == 4'd0) ? key_q[255:128] :
               (NK == 8 && k_q == 4'd1) ? key_q[127:0] : {w0, w1, w2, w3};
    end

    assign empty          = ~|sv_q;
    assign stall          = sv_q[NR] && !out_ready;
    assign key_ready      = state_q == READY;
    assign key_load_ready = (state_q != EXPAND) && empty;
    assign load_go        = key_load && key_load_ready;
    assign in_ready       = key_ready && !stall && !load_go;
    assign out_valid      = sv_q[NR];
    assign out_data       = sv_q[NR] ? sd_q[NR] : '0;
    assign out_tag        = sv_q[NR] ? st_q[NR] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            key_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            for (int i = 0; i <= NR; i++) bank_q[i] <= '0;
        end else if (state_q == EXPAND) begin
            bank_q[k_q] <= rk_d;
            a_q         <= b_q;
            b_q         <= rk_d;
            k_q         <= k_q + 4'd1;
            if (k_q == 4'(NR)) state_q <= READY;
        end else if (load_go) begin
            state_q <= EXPAND;
            k_q     <= '0;
            key_q   <= 256'(key_in) << (256 - KEY_LEN);
        end
    end

    always_comb begin
        sd_d[0] = in_data ^ bank_q[0];
        for (int i = 1; i <= NR; i++) sd_d[i] = aes_round(sd_q[i-1], bank_q[i], i == NR);
    end

    // Data and tag registers need no reset: the valid chain gates everything visible
    always_ff @(posedge clk) begin
        if (rst) begin
            sv_q <= '0;
        end else if (!stall) begin
            sv_q    <= {sv_q[NR-1:0], in_valid && in_ready};
            st_q[0] <= in_tag;
            for (int i = 0; i <= NR; i++) sd_q[i] <= sd_d[i];
            for (int i = 1; i <= NR; i++) st_q[i] <= st_q[i-1];
        end
    end
endmodule

// File: tb/tb_aes_enc_pipe_param.sv
// tb_aes_enc_pipe_param: directed FIPS-197 / SP800-38A vectors against AES-128 and AES-256
// instances, covering key-load timing, latency, streaming, backpressure, re-key and reset.
module tb_aes_enc_pipe_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [127:0] key_in, in_data, out_data;
    logic         key_load, key_load_ready, key_ready, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]   in_tag, out_tag;

    logic [255:0] b_key_in;
    logic [127:0] b_in_data, b_out_data;
    logic         b_key_load, b_key_load_ready, b_key_ready, b_in_valid, b_in_ready;
    logic         b_out_valid, b_out_ready;
    logic [7:0]   b_in_tag, b_out_tag;

    int vecs = 0;
    int miscompares = 0;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic [127:0] pt_b [5] = '{128'h3243f6a8885a308d313198a2e0370734,
                               128'h6bc1bee22e409f96e93d7e117393172a,
                               128'hae2d8a571e03ac9c9eb76fac45af8e51,
                               128'h30c81c46a35ce411e5fbc1191a0a52ef,
                               128'hf69f2445df4f9b17ad2b417be66c3710};
    logic [127:0] ct_b [5] = '{128'h3925841d02dc09fbdc118597196a0b32,
                               128'h3ad77bb40d7a3660a89ecaf32466ef97,
                               128'hf5d3d58503b9699de785895a96fdbaaf,
                               128'h43b1cd7f598ece23881b00e3ed030688,
                               128'h7b0c785e27e8ad3f8223207104725dd4};

    aes_enc_pipe_param #(.KEY_LEN(128), .TAG_W(8)) u128 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
        .key_load_ready(key_load_ready), .key_ready(key_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    aes_enc_pipe_param #(.KEY_LEN(256), .TAG_W(8)) u256 (
        .clk(clk), .rst(rst), .key_in(b_key_in), .key_load(b_key_load),
        .key_load_ready(b_key_load_ready), .key_ready(b_key_ready),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_tag(b_out_tag)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load128(input logic [127:0] k, input bit with_data);
        int n;
        key_in   = k;
        key_load = 1'b1;
        in_valid = with_data;
        in_data  = PT_A;
        #1;
        chk("kl_ready_before_load", 128'(key_load_ready), 128'd1);
        if (with_data) chk("key_load_beats_in_ready", 128'(in_ready), 128'd0);
        tick();
        key_load = 1'b0;
        in_valid = 1'b0;
        n = 1;
        chk("key_ready_low_in_expand", 128'(key_ready), 128'd0);
        while (!key_ready && n < 40) begin
            tick();
            n++;
        end
        chk("key128_latency", 128'(n), 128'd12);
    endtask

    task automatic stream(input int n, input int tag0, input bit use_b, input int p_low,
                          input int kl_at, input bit chk_lat);
        int tx, rx, first_acc, first_out, last_out;
        bit acc, fire;
        tx = 0;
        rx = 0;
        first_acc = -1;
        first_out = -1;
        last_out = -1;
        for (int c = 0; c < 2000 && rx < n; c++) begin
            in_valid  = tx < n;
            in_data   = use_b ? pt_b[tx % 5] : PT_A;
            in_tag    = 8'(tag0 + tx);
            out_ready = $urandom_range(0, 99) >= p_low;
            key_load  = c == kl_at;
            key_in    = KEY_B;
            #1;
            if (c == kl_at) chk("key_load_ready_busy", 128'(key_load_ready), 128'd0);
            if (out_valid) begin
                chk("stream_tag", 128'(out_tag), 128'(8'(tag0 + rx)));
                chk("stream_data", out_data, use_b ? ct_b[rx % 5] : CT_A);
            end
            if (out_valid && !out_ready) chk("in_ready_in_stall", 128'(in_ready), 128'd0);
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (acc && first_acc < 0) first_acc = c;
            if (fire && first_out < 0) first_out = c;
            if (fire) last_out = c;
            tick();
            if (acc) tx++;
            if (fire) rx++;
        end
        in_valid  = 1'b0;
        key_load  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 128'(rx), 128'(n));
        if (chk_lat) begin
            chk("stream_first_latency", 128'(first_out - first_acc), 128'd11);
            chk("stream_back_to_back", 128'(last_out - first_out), 128'(n - 1));
        end
    endtask

    initial begin
        int n;
        key_in = '0; key_load = 0; in_valid = 0; in_data = '0; in_tag = '0; out_ready = 1;
        b_key_in = '0; b_key_load = 0; b_in_valid = 0; b_in_data = '0; b_in_tag = '0;
        b_out_ready = 1;
        tick();
        tick();
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_out_tag", 128'(out_tag), 128'd0);
        chk("rst_key_ready", 128'(key_ready), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_key_load_ready", 128'(key_load_ready), 128'd1);
        chk("rst256_key_load_ready", 128'(b_key_load_ready), 128'd1);
        rst = 1'b0;
        tick();

        // AES-128 FIPS-197 single block
        load128(KEY_A, 1'b0);
        in_valid = 1'b1; in_data = PT_A; in_tag = 8'h5a;
        #1;
        chk("in_ready_idle", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin tick(); n++; end
        chk("lat128", 128'(n), 128'd11);
        chk("ct128", out_data, CT_A);
        chk("tag128", 128'(out_tag), 128'h5a);
        tick();
        chk("after_out_valid", 128'(out_valid), 128'd0);
        chk("after_out_data", out_data, 128'd0);
        chk("after_out_tag", 128'(out_tag), 128'd0);

        // AES-256 FIPS-197 single block
        b_key_in = KEY_C; b_key_load = 1'b1;
        tick();
        b_key_load = 1'b0;
        n = 1;
        while (!b_key_ready && n < 40) begin tick(); n++; end
        chk("key256_latency", 128'(n), 128'd16);
        b_in_valid = 1'b1; b_in_data = PT_A; b_in_tag = 8'ha5;
        #1;
        chk("in_ready256", 128'(b_in_ready), 128'd1);
        tick();
        b_in_valid = 1'b0;
        n = 1;
        while (!b_out_valid && n < 40) begin tick(); n++; end
        chk("lat256", 128'(n), 128'd15);
        chk("ct256", b_out_data, CT_C);
        chk("tag256", 128'(b_out_tag), 128'ha5);

        // back-to-back stream, then random backpressure
        load128(KEY_B, 1'b0);
        stream(20, 0, 1'b1, 0, -1, 1'b1);
        stream(30, 20, 1'b1, 40, -1, 1'b0);

        // key_load in flight is ignored; re-key afterwards switches cleanly
        load128(KEY_A, 1'b1);
        stream(5, 60, 1'b0, 0, 3, 1'b0);
        chk("key_ready_kept", 128'(key_ready), 128'd1);
        stream(1, 70, 1'b0, 0, -1, 1'b0);
        load128(KEY_B, 1'b0);
        stream(5, 80, 1'b1, 0, -1, 1'b0);

        // reset during expansion
        key_in = KEY_A; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstx_key_ready", 128'(key_ready), 128'd0);
        chk("rstx_key_load_ready", 128'(key_load_ready), 128'd1);
        chk("rstx_out_valid", 128'(out_valid), 128'd0);

        // reset with six blocks in flight
        load128(KEY_B, 1'b0);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = pt_b[i % 5]; in_tag = 8'(90 + i);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstp_out_valid", 128'(out_valid), 128'd0);
        chk("rstp_out_data", out_data, 128'd0);
        chk("rstp_out_tag", 128'(out_tag), 128'd0);
        chk("rstp_key_ready", 128'(key_ready), 128'd0);
        chk("rstp_key_load_ready", 128'(key_load_ready), 128'd1);
        n = 0;
        repeat (14) begin
            tick();
            if (out_valid) n++;
        end
        chk("rstp_no_stale", 128'(n), 128'd0);
        load128(KEY_B, 1'b0);
        stream(5, 100, 1'b1, 0, -1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
